// File: rtl/up_sample_nn_sched_ctrl.sv
// ---------------------------------------------------------------------------
// up_sample_nn_sched_ctrl
//
// Affine loop-nest schedule controller for the nearest-neighbour up_sample
// compute stage. After a flush it waits START_DELAY cycles, then issues one
// iteration every II cycles. It walks a 3-deep loop nest
// (outer x row x col, column fastest) and raises done after the last
// iteration.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (priority over flush/stall)
//   flush      - synchronous restart pulse (start of frame)
//   stall      - downstream hold; freezes phase and indices in RUN
//   en         - op enable for the unified buffers (ren/wen)
//   ctrl_vars  - loop indices: [0]=outer, [1]=row, [2]=col
//   iter_count - iterations issued since the last flush
//   busy       - high while in DELAY or RUN
//   done       - high after the final iteration until flush/rst
// ---------------------------------------------------------------------------
module up_sample_nn_sched_ctrl #(
  parameter int WIDTH       = 16,
  parameter int EXT0        = 1,
  parameter int EXT1        = 128,
  parameter int EXT2        = 128,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall,
  output logic                  en,
  output logic [2:0][WIDTH-1:0] ctrl_vars,
  output logic [31:0]           iter_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] MAX0 = WIDTH'(EXT0 - 1);
  localparam logic [WIDTH-1:0] MAX1 = WIDTH'(EXT1 - 1);
  localparam logic [WIDTH-1:0] MAX2 = WIDTH'(EXT2 - 1);

  logic [1:0]       state_r,     state_s;
  logic [31:0]      delay_cnt_r, delay_cnt_s;
  logic [31:0]      phase_r,     phase_s;
  logic [WIDTH-1:0] idx0_r,      idx0_s;
  logic [WIDTH-1:0] idx1_r,      idx1_s;
  logic [WIDTH-1:0] idx2_r,      idx2_s;
  logic [31:0]      iter_cnt_r,  iter_cnt_s;
  logic             issue_s;
  logic             last_s;

  // Issue decode: an iteration fires on phase 0 of RUN when not held.
  always_comb begin
    issue_s = (state_r == ST_RUN) && (phase_r == 32'd0) && !stall;
    last_s  = (idx0_r == MAX0) && (idx1_r == MAX1) && (idx2_r == MAX2);
  end

  // Next-state logic for the schedule FSM, counters and loop indices.
  always_comb begin
    state_s     = state_r;
    delay_cnt_s = delay_cnt_r;
    phase_s     = phase_r;
    idx0_s      = idx0_r;
    idx1_s      = idx1_r;
    idx2_s      = idx2_r;
    iter_cnt_s  = iter_cnt_r;
    if (flush) begin
      // Restart wins over stall and aborts any frame in flight.
      delay_cnt_s = 32'd0;
      phase_s     = 32'd0;
      idx0_s      = {WIDTH{1'b0}};
      idx1_s      = {WIDTH{1'b0}};
      idx2_s      = {WIDTH{1'b0}};
      iter_cnt_s  = 32'd0;
      if (START_DELAY > 0) begin
        state_s = ST_DELAY;
      end else begin
        state_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_DELAY: begin
          // Stall is deliberately ignored while counting the start delay.
          if (delay_cnt_r == 32'(START_DELAY - 1)) begin
            state_s     = ST_RUN;
            delay_cnt_s = 32'd0;
          end else begin
            delay_cnt_s = delay_cnt_r + 32'd1;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (phase_r == 32'(II - 1)) begin
              phase_s = 32'd0;
            end else begin
              phase_s = phase_r + 32'd1;
            end
          end else begin
            phase_s = phase_r;
          end
          if (issue_s) begin
            iter_cnt_s = iter_cnt_r + 32'd1;
            if (last_s) begin
              state_s = ST_DONE;
              idx0_s  = {WIDTH{1'b0}};
              idx1_s  = {WIDTH{1'b0}};
              idx2_s  = {WIDTH{1'b0}};
            end else if (idx2_r == MAX2) begin
              idx2_s = {WIDTH{1'b0}};
              if (idx1_r == MAX1) begin
                idx1_s = {WIDTH{1'b0}};
                idx0_s = idx0_r + WIDTH'(1);
              end else begin
                idx1_s = idx1_r + WIDTH'(1);
              end
            end else begin
              idx2_s = idx2_r + WIDTH'(1);
            end
          end else begin
            iter_cnt_s = iter_cnt_r;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      delay_cnt_r <= 32'd0;
      phase_r     <= 32'd0;
      idx0_r      <= {WIDTH{1'b0}};
      idx1_r      <= {WIDTH{1'b0}};
      idx2_r      <= {WIDTH{1'b0}};
      iter_cnt_r  <= 32'd0;
    end else begin
      state_r     <= state_s;
      delay_cnt_r <= delay_cnt_s;
      phase_r     <= phase_s;
      idx0_r      <= idx0_s;
      idx1_r      <= idx1_s;
      idx2_r      <= idx2_s;
      iter_cnt_r  <= iter_cnt_s;
    end
  end

  // Output decode; rst forces the idle values even before its edge lands.
  always_comb begin
    if (rst) begin
      en         = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      ctrl_vars  = '0;
      iter_count = 32'd0;
    end else begin
      en           = issue_s;
      busy         = (state_r == ST_DELAY) || (state_r == ST_RUN);
      done         = (state_r == ST_DONE);
      ctrl_vars[0] = idx0_r;
      ctrl_vars[1] = idx1_r;
      ctrl_vars[2] = idx2_r;
      iter_count   = iter_cnt_r;
    end
  end

endmodule

// File: tb/tb_up_sample_nn_sched_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for up_sample_nn_sched_ctrl. Random rst/flush/stall are
// applied and every output is compared each cycle with a frame-level model.
// The model counts issued iterations linearly and derives the loop indices
// from that count by division.
// ---------------------------------------------------------------------------
module tb_up_sample_nn_sched_ctrl;

  localparam int W     = 16;
  localparam int E0    = 2;
  localparam int E1    = 2;
  localparam int E2    = 3;
  localparam int SD    = 2;
  localparam int IIV   = 2;
  localparam int TOTAL = E0 * E1 * E2;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                stall;
  logic                en;
  logic [2:0][W-1:0]   ctrl_vars;
  logic [31:0]         iter_count;
  logic                busy;
  logic                done;

  up_sample_nn_sched_ctrl #(
    .WIDTH(W), .EXT0(E0), .EXT1(E1), .EXT2(E2),
    .START_DELAY(SD), .II(IIV)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .en(en), .ctrl_vars(ctrl_vars), .iter_count(iter_count),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: mode 0 idle, 1 waiting start delay, 2 running, 3 done.
  int m_mode;
  int m_wait;   // start-delay cycles still to elapse
  int m_cool;   // non-stalled cycles before the next issue is allowed
  int m_k;      // iterations issued this frame
  int pulses;

  initial begin
    logic e_en;
    int   p_rst, p_flush, p_stall;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    m_mode = 0; m_wait = 0; m_cool = 0; m_k = 0; pulses = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // Directed start: reset, one clean frame, then a stalled frame.
      if (cyc < 3) begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
      end else if (cyc < 60) begin
        rst = 1'b0; flush = (cyc == 4); stall = 1'b0;
      end else if (cyc < 120) begin
        rst = 1'b0; flush = (cyc == 60);
        stall = (cyc >= 70 && cyc < 74) || (cyc >= 90 && cyc < 93);
      end else if (cyc == 130) begin
        rst = 1'b1; flush = 1'b1; stall = 1'b0;
      end else if (cyc == 128) begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
      end else if (cyc == 120) begin
        rst = 1'b0; flush = 1'b1; stall = 1'b1;
      end else if (cyc < 145) begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
      end else begin
        p_rst = 300; p_flush = 70; p_stall = 4;
        rst   = ($urandom_range(p_rst - 1) == 0);
        flush = ($urandom_range(p_flush - 1) == 0);
        stall = ($urandom_range(p_stall - 1) == 0);
      end
      #1;
      e_en = !rst && (m_mode == 2) && (m_cool == 0) && !stall;
      check("en",   {31'd0, en},   {31'd0, e_en});
      check("busy", {31'd0, busy}, {31'd0, !rst && (m_mode == 1 || m_mode == 2)});
      check("done", {31'd0, done}, {31'd0, !rst && (m_mode == 3)});
      check("iter", iter_count, rst ? 32'd0 : 32'(m_k));
      if (!rst && m_mode == 2) begin
        check("outer", {16'd0, ctrl_vars[0]}, 32'(m_k / (E1 * E2)));
        check("row",   {16'd0, ctrl_vars[1]}, 32'((m_k / E2) % E1));
        check("col",   {16'd0, ctrl_vars[2]}, 32'(m_k % E2));
      end else begin
        check("idx0", {16'd0, ctrl_vars[0]} | {16'd0, ctrl_vars[1]}
                      | {16'd0, ctrl_vars[2]}, 32'd0);
      end
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_k = 0; m_cool = 0;
      end else if (flush) begin
        m_k = 0; m_cool = 0;
        if (SD > 0) begin m_mode = 1; m_wait = SD; end
        else m_mode = 2;
      end else if (m_mode == 1) begin
        m_wait--;
        if (m_wait == 0) m_mode = 2;
      end else if (m_mode == 2) begin
        if (e_en) begin
          m_k++; pulses++;
          m_cool = IIV - 1;
          if (m_k == TOTAL) m_mode = 3;
        end else if (!stall && m_cool > 0) begin
          m_cool--;
        end
      end
      // The first directed frame must have completed its full count.
      if (cyc == 58) check("frame1_pulses", 32'(pulses), 32'(TOTAL));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
